// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating 8-bit wait counter; at_limit flags that a waiting requester
// has been held off for STARVE_LIMIT cycles or more.
module arb_wait_counter #(
  parameter int STARVE_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] count;

  // clr wins over inc so the granting edge always leaves the count at zero
  always_ff @(posedge clk) begin
    if (rst)
      count <= 8'd0;
    else if (clr)
      count <= 8'd0;
    else if (inc && (count != 8'hFF))
      count <= count + 8'd1;
  end

  assign at_limit = (count >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between I-cache and D-cache refills.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces D priority + starvation guard with round robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LINE_W       = DEF_LINE_W,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  state_t state, state_nxt;
  logic   d_req;
  logic   pick_i;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = D was granted last; reset to I so D takes the first contested grant
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst)
      last_d <= 1'b0;
    else if (state == IDLE && state_nxt == BUSY_I)
      last_d <= 1'b0;
    else if (state == IDLE && state_nxt == BUSY_D)
      last_d <= 1'b1;
  end

  assign pick_i = i_read && (!d_req || last_d);
`else
  logic at_limit;

  arb_wait_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (i_read && (state != BUSY_I)),
    .clr      (!i_read || (state == IDLE && state_nxt == BUSY_I)),
    .at_limit (at_limit)
  );

  assign pick_i = i_read && (!d_req || at_limit);
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_i)
          state_nxt = BUSY_I;
        else if (d_req)
          state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready)
          state_nxt = RELEASE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; the latched transaction is frozen until mem_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      grant     <= GNT_NONE;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt == BUSY_I) begin
            mem_read <= 1'b1;
            mem_addr <= i_addr;
            grant    <= GNT_I;
          end else if (state_nxt == BUSY_D) begin
            mem_read  <= !d_write;
            mem_write <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            grant     <= GNT_D;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            i_rdata  <= mem_rdata;
            i_ready  <= 1'b1;
            grant    <= GNT_NONE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_rdata   <= mem_rdata;
            d_ready   <= 1'b1;
            grant     <= GNT_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default build, STARVE_LIMIT=3).
module tb_mem_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ready;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic [1:0]        grant;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .LINE_W       (LINE_W),
    .STARVE_LIMIT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .grant     (grant)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_DB = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] LINE_D1 = {4{32'h1234_5678}};
  localparam logic [127:0] LINE_I2 = {4{32'h0BAD_F00D}};

  initial begin
    rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_mem_read",  128'(mem_read),  128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_i_ready",   128'(i_ready),   128'(0));
    chk("rst_d_ready",   128'(d_ready),   128'(0));
    chk("rst_grant",     128'(grant),     128'(0));
    chk("rst_mem_addr",  128'(mem_addr),  128'(0));
    chk("rst_i_rdata",   i_rdata,         128'(0));
    rst = 1'b0;
    step();

    // I-only read, memory answers after 5 cycles
    i_read = 1'b1; i_addr = 28'h0000010;
    step();
    chk("i_mem_read",  128'(mem_read),  128'(1));
    chk("i_mem_write", 128'(mem_write), 128'(0));
    chk("i_mem_addr",  128'(mem_addr),  128'h10);
    chk("i_grant",     128'(grant),     128'(1));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("i_hold_read", 128'(mem_read), 128'(1));
    end
    mem_ready = 1'b1; mem_rdata = LINE_A5;
    step();
    chk("i_ready_pulse", 128'(i_ready),  128'(1));
    chk("i_rdata",       i_rdata,        LINE_A5);
    chk("i_done_read",   128'(mem_read), 128'(0));
    chk("i_done_grant",  128'(grant),    128'(0));
    mem_ready = 1'b0; i_read = 1'b0;
    step();
    chk("i_ready_one",   128'(i_ready),   128'(0));
    chk("i_state_idle",  128'(dut.state), 128'(0));

    // Stray mem_ready in IDLE is ignored
    mem_ready = 1'b1;
    step();
    chk("idle_rdy_i",     128'(i_ready),   128'(0));
    chk("idle_rdy_d",     128'(d_ready),   128'(0));
    chk("idle_rdy_state", 128'(dut.state), 128'(0));
    chk("idle_rdy_read",  128'(mem_read),  128'(0));
    mem_ready = 1'b0;

    // D write
    d_write = 1'b1; d_addr = 28'h0000020; d_wdata = LINE_DB;
    step();
    chk("dw_mem_write", 128'(mem_write), 128'(1));
    chk("dw_mem_read",  128'(mem_read),  128'(0));
    chk("dw_mem_addr",  128'(mem_addr),  128'h20);
    chk("dw_mem_wdata", mem_wdata,       LINE_DB);
    chk("dw_grant",     128'(grant),     128'(2));
    mem_ready = 1'b1; mem_rdata = '0;
    step();
    chk("dw_d_ready",   128'(d_ready),   128'(1));
    chk("dw_no_i_rdy",  128'(i_ready),   128'(0));
    chk("dw_write_off", 128'(mem_write), 128'(0));
    d_write = 1'b0; mem_ready = 1'b0;
    step();
    chk("dw_d_ready_one", 128'(d_ready), 128'(0));
    step();

    // Simultaneous I and D reads: D first, I after D's RELEASE
    i_read = 1'b1; i_addr = 28'h0000030; d_read = 1'b1; d_addr = 28'h0000040;
    step();
    chk("sim_grant_d", 128'(grant),    128'(2));
    chk("sim_addr_d",  128'(mem_addr), 128'h40);
    chk("sim_read_d",  128'(mem_read), 128'(1));
    mem_ready = 1'b1; mem_rdata = LINE_D1;
    step();
    chk("sim_d_ready", 128'(d_ready), 128'(1));
    chk("sim_d_rdata", d_rdata,       LINE_D1);
    d_read = 1'b0; mem_ready = 1'b0;
    step();
    chk("sim_release_grant", 128'(grant), 128'(0));
    step();
    chk("sim_grant_i", 128'(grant),    128'(1));
    chk("sim_addr_i",  128'(mem_addr), 128'h30);
    mem_ready = 1'b1; mem_rdata = LINE_I2;
    step();
    chk("sim_i_ready", 128'(i_ready), 128'(1));
    chk("sim_i_rdata", i_rdata,       LINE_I2);
    i_read = 1'b0; mem_ready = 1'b0;
    step(); step();

    // Starvation: D held continuously, latency 1, limit 3
    i_read = 1'b1; i_addr = 28'h0000050; d_read = 1'b1; d_addr = 28'h0000060;
    step();
    chk("stv_first_d", 128'(grant), 128'(2));
    mem_ready = 1'b1; mem_rdata = '0;
    step();
    chk("stv_d_ready", 128'(d_ready), 128'(1));
    mem_ready = 1'b0;
    step();
    chk("stv_release", 128'(grant), 128'(0));
    step();
    chk("stv_grant_i", 128'(grant),    128'(1));
    chk("stv_addr_i",  128'(mem_addr), 128'h50);
`ifndef MEM_ARB_ROUND_ROBIN_EN
    chk("stv_cnt_zero", 128'(dut.u_wait_cnt.count), 128'(0));
`endif
    mem_ready = 1'b1;
    step();
    chk("stv_i_ready", 128'(i_ready), 128'(1));
    i_read = 1'b0; mem_ready = 1'b0;
    step(); step();
    chk("stv_next_d", 128'(grant),    128'(2));
    chk("stv_d_addr", 128'(mem_addr), 128'h60);

    // Reset while BUSY_D abandons the transaction
    rst = 1'b1; d_read = 1'b0;
    step();
    chk("rstb_read",  128'(mem_read),  128'(0));
    chk("rstb_write", 128'(mem_write), 128'(0));
    chk("rstb_d_rdy", 128'(d_ready),   128'(0));
    chk("rstb_grant", 128'(grant),     128'(0));
    chk("rstb_state", 128'(dut.state), 128'(0));
    rst = 1'b0; mem_ready = 1'b1;
    step();
    chk("rstb_late_rdy", 128'(d_ready),   128'(0));
    chk("rstb_late_st",  128'(dut.state), 128'(0));
    mem_ready = 1'b0;
    step();

    // Address change and request drop during BUSY_I are ignored
    i_read = 1'b1; i_addr = 28'h0000070;
    step();
    chk("chg_grant", 128'(mem_addr), 128'h70);
    i_addr = 28'h0000071;
    step();
    chk("chg_addr_held", 128'(mem_addr), 128'h70);
    chk("chg_read_held", 128'(mem_read), 128'(1));
    i_read = 1'b0;
    step();
    chk("chg_drop_read",  128'(mem_read),  128'(1));
    chk("chg_drop_state", 128'(dut.state), 128'(1));
    mem_ready = 1'b1; mem_rdata = LINE_A5;
    step();
    chk("chg_i_ready", 128'(i_ready), 128'(1));
    mem_ready = 1'b0;
    step();
    chk("chg_i_ready_off", 128'(i_ready), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
